// File: rtl/char_norm_pkg.sv
// rtl/char_norm_pkg.sv - shared types, byte constants and classifier for the character normalizer
package char_norm_pkg;

  typedef enum logic [1:0] {START, WORD, SPACE, FLUSH} norm_state_t;
  typedef enum logic [1:0] {UPPER, WS, PRINT, CTRL} char_class_t;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_CASE_OFS = 8'h20;

  function automatic char_class_t classify(input logic [7:0] b);
    char_class_t c;
    if (b >= 8'h41 && b <= 8'h5A)
      c = UPPER;
    else if (b == CH_SPACE || b == CH_TAB || b == CH_LF || b == CH_CR)
      c = WS;
    else if (b >= 8'h21 && b <= 8'h7E)
      c = PRINT;
    else
      c = CTRL;
    return c;
  endfunction

endpackage

// File: rtl/char_normalizer_if.sv
// rtl/char_normalizer_if.sv - input/output byte stream handshake bundle for the normalizer
interface char_normalizer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/char_norm_fifo.sv
// rtl/char_norm_fifo.sv - byte FIFO with wrap-bit pointers; head reads 0x00 while empty
module char_norm_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]       mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]) && (wr_q[IDX_W] != rd_q[IDX_W]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + PTR_W'(do_push);
  assign rd_d    = rd_q + PTR_W'(do_pop);
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_q[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: empty state masks stale entries on head_o.
  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q[IDX_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/char_normalizer.sv
// rtl/char_normalizer.sv - folds case, collapses whitespace, drops control bytes, terminates streams with a space
// CHAR_NORM_DROP_CNT_EN enables the saturating dropped-control-byte counter.
module char_normalizer
  import char_norm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  char_normalizer_if.slave bus,
  output logic [CNT_W-1:0] drop_cnt
);

  norm_state_t state_q, state_d;
  char_class_t cls;
  logic        full, empty, in_ready, accept, push;
  logic [7:0]  push_data, mapped;

  assign cls      = classify(bus.in_data);
  assign in_ready = !full && (state_q != FLUSH);
  assign accept   = bus.in_valid && in_ready;
  assign mapped   = (cls == UPPER) ? bus.in_data + CH_CASE_OFS : bus.in_data;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = CH_SPACE;
    if (state_q == FLUSH) begin
      if (!full) begin
        push    = 1'b1;
        state_d = START;
      end
    end else if (accept) begin
      case (cls)
        UPPER, PRINT: begin
          push      = 1'b1;
          push_data = mapped;
          state_d   = WORD;
        end
        WS: begin
          if (state_q == WORD) begin
            push    = 1'b1;
            state_d = SPACE;
          end
        end
        default: ;
      endcase
      // A stream ending mid-word still owes the checker a terminating space.
      if (bus.in_last)
        state_d = (state_d == WORD) ? FLUSH : START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= START;
    else
      state_q <= state_d;
  end

  char_norm_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.out_ready),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (bus.out_data)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !empty;

`ifdef CHAR_NORM_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && cls == CTRL && drop_q != {CNT_W{1'b1}})
      drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else
      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
